dram_arbiter: RTL and testbench

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter_pkg.sv | 30 +++
 rtl/dram_arbiter_if.sv | 39 +++
 rtl/dram_arbiter_rr_picker.sv | 32 +++
 rtl/dram_arbiter.sv | 144 ++++++++++++++
 tb/tb_dram_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared widths, burst geometry and state encoding for the DRAM port arbiter.
package dram_arbiter_pkg;

    localparam int unsigned ADDRESS_LEN        = 16;
    localparam int unsigned BURST_ACCESS_WIDTH = 32;
    localparam int unsigned BURST_LEN          = 4;
    localparam int unsigned ROW_WIDTH          = 128;
    localparam int unsigned WIDTH              = 32;
    localparam bit          PIM_ENABLE         = 1'b0;

    // Beats a well-formed burst must deliver before dram_complete.
    localparam int unsigned BURST_BEATS = (PIM_ENABLE != 1'b0) ? (ROW_WIDTH / WIDTH) : BURST_LEN;

    typedef logic [ADDRESS_LEN-1:0]        addr_t;
    typedef logic [BURST_ACCESS_WIDTH-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    // Command presented to the DRAM for the whole open burst.
    typedef struct packed {
        logic  read_en;
        logic  write_en;
        addr_t addr;
    } dram_cmd_t;

endpackage

// File: rtl/dram_arbiter_if.sv
// Requester-side and DRAM-side signals of the arbiter, bundled as one interface.
interface dram_arbiter_if import dram_arbiter_pkg::*; #(
    parameter int unsigned NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    addr_t [NUM_REQ-1:0]       req_addr;
    beat_t [NUM_REQ-1:0]       req_wdata;
    logic [NUM_REQ-1:0]        req_gnt;
    logic [NUM_REQ-1:0]        req_beat;
    logic [NUM_REQ-1:0]        req_done;
    beat_t                     rsp_rdata;
    logic                      err;

    addr_t                     addr;
    logic                      read_en;
    logic                      write_en;
    beat_t                     wdata;
    logic                      dram_ready;
    logic                      dram_complete;
    logic                      valid;
    beat_t                     rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  dram_ready, dram_complete, valid, rdata,
        output req_gnt, req_beat, req_done, rsp_rdata, err,
        output addr, read_en, write_en, wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output dram_ready, dram_complete, valid, rdata,
        input  req_gnt, req_beat, req_done, rsp_rdata, err,
        input  addr, read_en, write_en, wdata
    );

endinterface

// File: rtl/dram_arbiter_rr_picker.sv
// Round-robin pick: first requesting index after ptr, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       valid_c,
    output logic [NUM_REQ-1:0]         onehot_c,
    output logic [$clog2(NUM_REQ)-1:0] idx_c
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    // Offsets 1..NUM_REQ from ptr; the nearest requester wins, ptr itself is last.
    always_comb begin
        valid_c  = 1'b0;
        onehot_c = '0;
        idx_c    = '0;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!valid_c && req[cand]) begin
                valid_c        = 1'b1;
                onehot_c[cand] = 1'b1;
                idx_c          = cand;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters one DRAM burst at a time,
// with beat-count checking and a burst watchdog feeding a sticky error flag.
module dram_arbiter import dram_arbiter_pkg::*; #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    dram_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    dram_cmd_t          cmd_q, cmd_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic               end_burst;

    logic               pick_valid_c;
    logic [NUM_REQ-1:0] pick_oh_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic [NUM_REQ-1:0] owner_oh;
    logic               in_burst_c;
    logic [NUM_REQ-1:0] req_beat_c;
    beat_t              rsp_rdata_c;
    beat_t              wdata_c;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req      (bus.req_valid),
        .ptr      (ptr_q),
        .valid_c  (pick_valid_c),
        .onehot_c (pick_oh_c),
        .idx_c    (pick_idx_c)
    );

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // Beat strobe and data paths follow the DRAM directly, only while a burst is open.
    assign in_burst_c  = (state_q == BURST);
    assign req_beat_c  = (in_burst_c && bus.valid) ? owner_oh : '0;
    assign rsp_rdata_c = in_burst_c ? bus.rdata : '0;
    assign wdata_c     = in_burst_c ? bus.req_wdata[owner_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            owner_q    <= '0;
            cmd_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            beat_cnt_q <= '0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cmd_q      <= cmd_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            beat_cnt_q <= beat_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        gnt_d      = '0;
        done_d     = '0;
        err_d      = err_q;
        beat_cnt_d = beat_cnt_q;
        wd_cnt_d   = wd_cnt_q;
        end_burst  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.dram_ready && pick_valid_c) begin
                    owner_d        = pick_idx_c;
                    cmd_d.addr     = bus.req_addr[pick_idx_c];
                    cmd_d.write_en = bus.req_we[pick_idx_c];
                    cmd_d.read_en  = !bus.req_we[pick_idx_c];
                    gnt_d          = pick_oh_c;
                    beat_cnt_d     = '0;
                    wd_cnt_d       = '0;
                    state_d        = BURST;
                end
            end
            BURST: begin
                beat_cnt_d = beat_cnt_q + CNT_W'(bus.valid);
                wd_cnt_d   = wd_cnt_q + CNT_W'(1);
                // A beat arriving with dram_complete is part of the final count.
                if (bus.dram_complete) begin
                    end_burst = 1'b1;
                    if (beat_cnt_d != CNT_W'(BURST_BEATS)) begin
                        err_d = 1'b1;
                    end
                end else if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    end_burst = 1'b1;
                    err_d     = 1'b1;
                end
                if (end_burst) begin
                    cmd_d   = '0;
                    done_d  = owner_oh;
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_gnt   = gnt_q;
    assign bus.req_done  = done_q;
    assign bus.err       = err_q;
    assign bus.addr      = cmd_q.addr;
    assign bus.read_en   = cmd_q.read_en;
    assign bus.write_en  = cmd_q.write_en;
    assign bus.req_beat  = req_beat_c;
    assign bus.rsp_rdata = rsp_rdata_c;
    assign bus.wdata     = wdata_c;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: expected grants queued as requests are raised,
// popped and checked when the arbiter grants.
module tb_dram_arbiter;
    import dram_arbiter_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned TO   = 16;

    typedef struct {
        int    owner;
        logic  we;
        addr_t addr;
    } exp_t;

    logic   clk;
    logic   rst_n;
    int     n_tests = 0;
    int     n_fail  = 0;
    exp_t   sb[$];
    exp_t   te;
    logic [3:0] toh;

    dram_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    dram_arbiter #(
        .NUM_REQ (NREQ),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench stalled");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_burst(input int owner, input logic we, input addr_t a);
        exp_t e;
        e.owner = owner;
        e.we    = we;
        e.addr  = a;
        sb.push_back(e);
    endtask

    // Waits (bounded) for a grant, checks it against the oldest expectation,
    // then perturbs the owner's request fields to prove the arbiter latched them.
    task automatic wait_gnt(input logic [3:0] valid_after, output exp_t e, output logic [3:0] oh);
        bit got = 1'b0;
        int c   = 0;
        while (!got && c < 40) begin
            tick();
            c++;
            got = (bus.req_gnt !== 4'b0000);
        end
        chk("gnt_seen", 64'(got), 64'd1);
        e.owner = 0;
        e.we    = 1'b0;
        e.addr  = '0;
        if (sb.size() > 0) e = sb.pop_front();
        oh = 4'b0001 << e.owner;
        chk("gnt", 64'(bus.req_gnt), 64'(oh));
        chk("gnt_addr", 64'(bus.addr), 64'(e.addr));
        chk("gnt_read_en", 64'(bus.read_en), 64'(!e.we));
        chk("gnt_write_en", 64'(bus.write_en), 64'(e.we));
        bus.req_valid = valid_after;
        bus.req_addr[2'(e.owner)] = ~e.addr;
        bus.req_we[2'(e.owner)]   = ~e.we;
    endtask

    task automatic run_burst(input logic [3:0] valid_after, input int nbeats,
                             input bit comp_last, input bit exp_err);
        exp_t       e;
        logic [3:0] oh;
        beat_t      rd;
        wait_gnt(valid_after, e, oh);
        for (int b = 0; b < nbeats; b++) begin
            rd        = beat_t'($urandom());
            bus.rdata = rd;
            bus.valid = 1'b1;
            for (int r = 0; r < 4; r++) bus.req_wdata[r] = 32'hDEAD_0000 | 32'(r);
            bus.req_wdata[2'(e.owner)] = 32'(b);
            bus.dram_complete = comp_last && (b == nbeats - 1);
            #1;
            chk("beat", 64'(bus.req_beat), 64'(oh));
            if (e.we) chk("wdata", 64'(bus.wdata), 64'(b));
            else      chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(rd));
            tick();
            if (!(comp_last && (b == nbeats - 1))) begin
                chk("gnt_pulse", 64'(bus.req_gnt), 64'd0);
                chk("hold_addr", 64'(bus.addr), 64'(e.addr));
                chk("hold_en", 64'({bus.write_en, bus.read_en}), 64'({e.we, !e.we}));
            end
        end
        bus.valid = 1'b0;
        if (!comp_last) begin
            bus.dram_complete = 1'b1;
            #1;
            chk("beat_idle", 64'(bus.req_beat), 64'd0);
            tick();
        end
        bus.dram_complete = 1'b0;
        chk("done", 64'(bus.req_done), 64'(oh));
        chk("en_off", 64'({bus.write_en, bus.read_en}), 64'd0);
        chk("addr_off", 64'(bus.addr), 64'd0);
        chk("err", 64'(bus.err), 64'(exp_err));
        chk("rdata_gated", 64'(bus.rsp_rdata), 64'd0);
        chk("wdata_gated", 64'(bus.wdata), 64'd0);
        bus.req_addr[2'(e.owner)] = e.addr;
        bus.req_we[2'(e.owner)]   = e.we;
        tick();
        chk("done_pulse", 64'(bus.req_done), 64'd0);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.req_valid     = '0;
        bus.req_we        = '0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.dram_ready    = 1'b0;
        bus.dram_complete = 1'b0;
        bus.valid         = 1'b0;
        bus.rdata         = '0;
        #1;
        chk("rst_gnt", 64'(bus.req_gnt), 64'd0);
        chk("rst_done", 64'(bus.req_done), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_en", 64'({bus.write_en, bus.read_en}), 64'd0);
        chk("rst_addr", 64'(bus.addr), 64'd0);
        chk("rst_beat", 64'(bus.req_beat), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", 64'(bus.req_gnt), 64'd0);

        // Round robin with everyone requesting: 0,1,2,3,0.
        bus.dram_ready = 1'b1;
        for (int i = 0; i < 4; i++) bus.req_addr[i] = addr_t'(i * 256);
        expect_burst(0, 1'b0, 16'h0000);
        expect_burst(1, 1'b0, 16'h0100);
        expect_burst(2, 1'b0, 16'h0200);
        expect_burst(3, 1'b0, 16'h0300);
        expect_burst(0, 1'b0, 16'h0000);
        bus.req_valid = 4'hF;
        for (int k = 0; k < 4; k++) run_burst(4'hF, 4, 1'b1, 1'b0);
        run_burst(4'h0, 4, 1'b1, 1'b0);

        // Single read by requester 2.
        bus.req_addr[2] = 16'h0040;
        bus.req_we[2]   = 1'b0;
        expect_burst(2, 1'b0, 16'h0040);
        bus.req_valid = 4'b0100;
        run_burst(4'h0, 4, 1'b0, 1'b0);

        // Write by requester 1, held off while the DRAM is not ready.
        bus.dram_ready  = 1'b0;
        bus.req_we[1]   = 1'b1;
        bus.req_addr[1] = 16'h1234;
        bus.req_valid   = 4'b0010;
        repeat (3) begin
            tick();
            chk("not_ready_gnt", 64'(bus.req_gnt), 64'd0);
            chk("not_ready_en", 64'(bus.write_en), 64'd0);
        end
        bus.dram_ready = 1'b1;
        expect_burst(1, 1'b1, 16'h1234);
        run_burst(4'h0, 4, 1'b0, 1'b0);

        // Watchdog: no dram_complete, enables drop 16 cycles after grant.
        bus.req_we[2]   = 1'b0;
        bus.req_addr[2] = 16'h0200;
        expect_burst(2, 1'b0, 16'h0200);
        bus.req_valid = 4'b0100;
        wait_gnt(4'h0, te, toh);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("to_hold", 64'(bus.read_en), 64'd1);
        end
        tick();
        chk("to_en_drop", 64'(bus.read_en), 64'd0);
        chk("to_done", 64'(bus.req_done), 64'(toh));
        chk("to_err", 64'(bus.err), 64'd1);
        bus.req_addr[2] = 16'h0200;
        bus.req_we[2]   = 1'b0;
        tick();
        chk("to_done_pulse", 64'(bus.req_done), 64'd0);
        chk("to_err_sticky", 64'(bus.err), 64'd1);

        // Reset during beat 2 of requester 3's burst.
        bus.req_addr[3] = 16'h0300;
        bus.req_we[3]   = 1'b0;
        expect_burst(3, 1'b0, 16'h0300);
        bus.req_valid = 4'b1000;
        wait_gnt(4'h0, te, toh);
        bus.valid = 1'b1;
        bus.rdata = 32'h0000_0001;
        tick();
        bus.rdata = 32'h0000_0002;
        #1;
        chk("mid_beat2", 64'(bus.req_beat), 64'(toh));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 64'({bus.write_en, bus.read_en}), 64'd0);
        chk("mid_rst_addr", 64'(bus.addr), 64'd0);
        chk("mid_rst_err", 64'(bus.err), 64'd0);
        chk("mid_rst_done", 64'(bus.req_done), 64'd0);
        chk("mid_rst_beat", 64'(bus.req_beat), 64'd0);
        bus.valid       = 1'b0;
        bus.req_addr[3] = 16'h0300;
        bus.req_we[3]   = 1'b0;
        tick();
        chk("mid_rst_done_hold", 64'(bus.req_done), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", 64'(bus.req_done), 64'd0);
        chk("post_rst_gnt", 64'(bus.req_gnt), 64'd0);

        // After reset requester 0 wins over 3; 3 then under-delivers beats.
        bus.req_addr[0] = 16'h0010;
        bus.req_we[0]   = 1'b0;
        expect_burst(0, 1'b0, 16'h0010);
        expect_burst(3, 1'b0, 16'h0300);
        bus.req_valid = 4'b1001;
        run_burst(4'b1000, 4, 1'b1, 1'b0);
        run_burst(4'b0000, 3, 1'b0, 1'b1);

        // Error stays set and the next burst is still serviced.
        bus.req_addr[1] = 16'h0500;
        bus.req_we[1]   = 1'b0;
        expect_burst(1, 1'b0, 16'h0500);
        bus.req_valid = 4'b0010;
        run_burst(4'h0, 4, 1'b1, 1'b1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
